// File: rtl/tx_port_pkg.sv
// Shared definitions for the TX port transaction parser: FSM states and FIFO framing constants.
`timescale 1ns/1ps
package tx_port_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_OFF   = 3'd1,
        S_HDR   = 3'd2,
        S_DATA  = 3'd3,
        S_END2  = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int C_PORT_DATA_WIDTH = 32;
    localparam int C_MARKER_BIT      = C_PORT_DATA_WIDTH;

    // End-of-transaction marker word as it appears in the FIFO.
    localparam logic [C_PORT_DATA_WIDTH:0] C_END_MARKER = {1'b1, 32'h0};

endpackage

// File: rtl/tx_port_txn_out_reg_32.sv
// One-entry output register for the data stream; a load and a take may coincide,
// which keeps the register full with the new word and sustains one word per cycle.
`timescale 1ns/1ps
module tx_port_txn_out_reg_32
    import tx_port_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         i_load,
    input  logic [C_PORT_DATA_WIDTH-1:0] i_data,
    input  logic                         i_take,
    output logic [C_PORT_DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_free
);

    logic [C_PORT_DATA_WIDTH-1:0] r_data;
    logic                         r_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    // A take of an empty register is meaningless, so it does not free anything extra.
    assign o_free  = !r_valid || i_take;
    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/tx_port_txn_parser_32.sv
// Parses the framed TX FIFO stream (length, offset/last, data, two end markers) into
// a header handshake, a data stream and a completion report.
`timescale 1ns/1ps
module tx_port_txn_parser_32
    import tx_port_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
    input  logic                         RD_EMPTY,
    output logic                         RD_EN,
    output logic                         TXN,
    input  logic                         TXN_ACK,
    output logic [C_DATA_WIDTH-1:0]      TXN_LEN,
    output logic [C_DATA_WIDTH-2:0]      TXN_OFF,
    output logic                         TXN_LAST,
    output logic [C_DATA_WIDTH-1:0]      DATA,
    output logic                         DATA_VALID,
    input  logic                         DATA_REN,
    output logic                         DONE,
    input  logic                         DONE_ACK,
    output logic [C_DATA_WIDTH-1:0]      DONE_LEN,
    output logic                         DONE_OVF,
    output logic                         ERR
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [C_DATA_WIDTH-1:0] r_len;
    logic [C_DATA_WIDTH-1:0] r_count;
    logic [C_DATA_WIDTH-2:0] r_off;
    logic                    r_last;
    logic                    r_ovf;
    logic                    r_err;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_err;
    logic                    w_marker;
    logic                    w_reg_free;
    logic                    w_under_len;

    assign w_marker    = RD_DATA[C_MARKER_BIT];
    assign w_under_len = (r_count < r_len);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: if (!RD_EMPTY) begin
                w_pop = 1'b1;
                if (w_marker) w_state_next = S_OFF;
                else          w_err        = 1'b1;
            end
            S_OFF: if (!RD_EMPTY) begin
                w_pop        = 1'b1;
                w_state_next = S_HDR;
            end
            S_HDR: if (TXN_ACK) w_state_next = S_DATA;
            // End markers bypass the output register; data words wait for room.
            S_DATA: if (!RD_EMPTY) begin
                if (w_marker) begin
                    w_pop        = 1'b1;
                    w_state_next = S_END2;
                end else if (w_reg_free) begin
                    w_pop  = 1'b1;
                    w_load = w_under_len;
                end
            end
            S_END2: if (!RD_EMPTY) begin
                w_pop = 1'b1;
                if (w_marker) w_state_next = S_DRAIN;
                else          w_err        = 1'b1;
            end
            S_DRAIN: if (!DATA_VALID) w_state_next = S_DONE;
            S_DONE:  if (DONE_ACK)    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_count <= '0;
            r_off   <= '0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err;
            if (r_state == S_IDLE && w_pop && w_marker) begin
                r_len   <= RD_DATA[C_DATA_WIDTH-1:0];
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            // The marker bit of the offset word carries no meaning.
            if (r_state == S_OFF && w_pop) begin
                r_off  <= RD_DATA[C_DATA_WIDTH-1:1];
                r_last <= RD_DATA[0];
            end
            if (w_load) r_count <= r_count + 1'b1;
            if (r_state == S_DATA && w_pop && !w_marker && !w_under_len) r_ovf <= 1'b1;
        end
    end

    tx_port_txn_out_reg_32 u_out_reg (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_load  (w_load),
        .i_data  (RD_DATA[C_DATA_WIDTH-1:0]),
        .i_take  (DATA_REN),
        .o_data  (DATA),
        .o_valid (DATA_VALID),
        .o_free  (w_reg_free)
    );

    // Reset holds the FSM in IDLE, which would otherwise pop; gate the pop explicitly.
    assign RD_EN    = w_pop && RST_N;
    assign TXN      = (r_state == S_HDR);
    assign DONE     = (r_state == S_DONE);
    assign TXN_LEN  = r_len;
    assign TXN_OFF  = r_off;
    assign TXN_LAST = r_last;
    assign DONE_LEN = r_count;
    assign DONE_OVF = r_ovf;
    assign ERR      = r_err;

endmodule
